mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
//  Bus controller directly downstream of the 16-bit processor's memory port.
//  Converts single-cycle MEM_RD/MEM_WR strobes into a REQ/ACK transaction on a slower external memory.
//  Stalls the core while a transaction is in flight, and returns registered read data on READ_DATA_BUS.
//  Flags unacknowledged accesses with a timeout error.
// PARAMETERS
//  ADDR_W   16  address width, CPU and external side
//  DATA_W   16  data width, CPU and external side
//  TIMEOUT  15  max EXT_REQ cycles without EXT_ACK before abort (1..255)
// PORTS
//  MAIN_CLK        in   1       single clock, rising edge
//  MAIN_RST        in   1       asynchronous reset, active-high
//  ADDR_BUS        in   ADDR_W  CPU address
//  WRITE_DATA_BUS  in   DATA_W  CPU write data
//  MEM_RD          in   1       CPU read strobe
//  MEM_WR          in   1       CPU write strobe
//  READ_DATA_BUS   out  DATA_W  registered read data to CPU
//  CPU_STALL       out  1       hold core while access pending
//  BUS_ERR         out  1       1-cycle pulse on timeout
//  EXT_ADDR        out  ADDR_W  latched address to memory
//  EXT_WDATA       out  DATA_W  latched write data to memory
//  EXT_WE          out  1       1 = write transaction, 0 = read
//  EXT_REQ         out  1       transaction request, held until ACK/timeout
//  EXT_RDATA       in   DATA_W  memory read data, valid with EXT_ACK
//  EXT_ACK         in   1       memory completion, sampled while EXT_REQ=1
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; all outputs 0; timeout counter 0.
//  Reset mid-transaction drops EXT_REQ the same instant. Any in-flight access is abandoned.
//  FSM states: IDLE, REQ, DONE, ERR.
//  IDLE: MEM_RD|MEM_WR high at edge -> REQ.
//   - On that edge, latch ADDR_BUS->EXT_ADDR and WRITE_DATA_BUS->EXT_WDATA.
//   - Set EXT_WE=MEM_WR. If both strobes are high, the write wins and no read is issued.
//  REQ: EXT_REQ=1. The counter increments each cycle.
//   - EXT_ACK=1 at edge -> DONE. For a read, capture EXT_RDATA into READ_DATA_BUS on that edge.
//   - Counter reaches TIMEOUT with no ACK -> ERR.
//  ERR: one cycle. EXT_REQ=0, BUS_ERR=1. For a read, READ_DATA_BUS<=all ones. Then -> DONE.
//  DONE: EXT_REQ=0. Stay while MEM_RD|MEM_WR is high; go to IDLE when both are low.
//   - So one strobe yields exactly one transaction.
//   - The core must drop its strobes for >=1 cycle between accesses.
//  CPU_STALL (combinational) = (state==REQ) | (state==ERR) | (state==IDLE & (MEM_RD|MEM_WR)).
//   - Stall rises in the same cycle as the strobe. It is low in DONE.
//  Latency: ACK on the first REQ cycle gives a 2-cycle stall (IDLE + REQ).
//   - Each extra wait cycle adds 1. Max stall is TIMEOUT+2.
//  READ_DATA_BUS holds its last value until the next read completes or errors. Writes never change it.
//  EXT_ADDR, EXT_WDATA and EXT_WE stay stable from REQ entry until the next IDLE->REQ.
//  EXT_ACK is ignored in IDLE, DONE and ERR; a late ACK after a timeout has no effect.
//  Strobe changes during REQ are ignored. The latched request completes.
//  Counter is 8 bits and clears on REQ entry. No wrap is possible since TIMEOUT<=255.
// TESTING
//  1. Read, 0-wait: MEM_RD=1, ADDR=16'h0040; ACK on 1st REQ cycle with RDATA=16'hBEEF
//     -> EXT_ADDR=0040, EXT_WE=0; STALL high exactly 2 cycles; READ_DATA_BUS=BEEF.
//  2. Write, 3-wait: MEM_WR=1, ADDR=16'h0100, WDATA=16'h1234; ACK after 3 REQ cycles
//     -> EXT_WE=1, EXT_WDATA=1234 stable throughout; STALL 5 cycles; READ_DATA_BUS unchanged.
//  3. Timeout: MEM_RD=1, never ACK, TIMEOUT=15 -> EXT_REQ high 15 cycles; BUS_ERR 1-cycle pulse;
//     READ_DATA_BUS=FFFF; a late ACK 5 cycles later is ignored.
//  4. Simultaneous MEM_RD=MEM_WR=1 -> one write transaction only.
//     Holding strobes high after DONE issues no second request.
//  5. Assert MAIN_RST during REQ (cycle 2 of wait) -> EXT_REQ, STALL, BUS_ERR go 0 asynchronously;
//     after release, a read of 16'h0002 completes normally.
//  6. Back-to-back reads with a 1-cycle strobe gap -> two transactions; second data replaces first.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// CPU memory-port bridge: one strobe becomes one REQ/ACK transaction on external memory.
// Stall is 2 cycles with ACK on the first REQ cycle, plus 1 per wait cycle, up to TIMEOUT+2 on abort.
module mem_bus_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              MAIN_CLK,
  input  logic              MAIN_RST,
  input  logic [ADDR_W-1:0] ADDR_BUS,
  input  logic [DATA_W-1:0] WRITE_DATA_BUS,
  input  logic              MEM_RD,
  input  logic              MEM_WR,
  output logic [DATA_W-1:0] READ_DATA_BUS,
  output logic              CPU_STALL,
  output logic              BUS_ERR,
  output logic [ADDR_W-1:0] EXT_ADDR,
  output logic [DATA_W-1:0] EXT_WDATA,
  output logic              EXT_WE,
  output logic              EXT_REQ,
  input  logic [DATA_W-1:0] EXT_RDATA,
  input  logic              EXT_ACK
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              r_req;
  logic              r_err;

  logic              w_strobe;
  logic [7:0]        w_cnt_nxt;

  assign w_strobe  = MEM_RD | MEM_WR;
  assign w_cnt_nxt = r_cnt + 8'd1;

  always_ff @(posedge MAIN_CLK or posedge MAIN_RST) begin
    if (MAIN_RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_strobe) begin
            r_state <= S_REQ;
            r_addr  <= ADDR_BUS;
            r_wdata <= WRITE_DATA_BUS;
            r_we    <= MEM_WR;
            r_req   <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_REQ: begin
          if (EXT_ACK) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            if (!r_we) r_rdata <= EXT_RDATA;
          end else if (w_cnt_nxt == TO_LIM) begin
            // Error data and the BUS_ERR pulse both become visible during ERR.
            r_state <= S_ERR;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_cnt   <= w_cnt_nxt;
            if (!r_we) r_rdata <= '1;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_ERR: begin
          r_err   <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!w_strobe) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign READ_DATA_BUS = r_rdata;
  assign EXT_ADDR      = r_addr;
  assign EXT_WDATA     = r_wdata;
  assign EXT_WE        = r_we;
  assign EXT_REQ       = r_req;
  assign BUS_ERR       = r_err;
  // Gated by reset so a strobe held through reset cannot raise stall.
  assign CPU_STALL     = !MAIN_RST & ((r_state == S_REQ) | (r_state == S_ERR) |
                                      ((r_state == S_IDLE) & w_strobe));

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized transaction-level bench for mem_bus_ctrl against a per-transaction expectation model.
module tb_mem_bus_ctrl;
  localparam int TIMEOUT = 15;

  logic        MAIN_CLK;
  logic        MAIN_RST;
  logic [15:0] ADDR_BUS;
  logic [15:0] WRITE_DATA_BUS;
  logic        MEM_RD;
  logic        MEM_WR;
  logic [15:0] READ_DATA_BUS;
  logic        CPU_STALL;
  logic        BUS_ERR;
  logic [15:0] EXT_ADDR;
  logic [15:0] EXT_WDATA;
  logic        EXT_WE;
  logic        EXT_REQ;
  logic [15:0] EXT_RDATA;
  logic        EXT_ACK;

  int          n_cmp;
  int          n_bad;
  logic [15:0] exp_rdata;

  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
    .MAIN_CLK       (MAIN_CLK),
    .MAIN_RST       (MAIN_RST),
    .ADDR_BUS       (ADDR_BUS),
    .WRITE_DATA_BUS (WRITE_DATA_BUS),
    .MEM_RD         (MEM_RD),
    .MEM_WR         (MEM_WR),
    .READ_DATA_BUS  (READ_DATA_BUS),
    .CPU_STALL      (CPU_STALL),
    .BUS_ERR        (BUS_ERR),
    .EXT_ADDR       (EXT_ADDR),
    .EXT_WDATA      (EXT_WDATA),
    .EXT_WE         (EXT_WE),
    .EXT_REQ        (EXT_REQ),
    .EXT_RDATA      (EXT_RDATA),
    .EXT_ACK        (EXT_ACK)
  );

  initial begin
    MAIN_CLK = 1'b0;
    forever #5 MAIN_CLK = ~MAIN_CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One CPU access. waits = extra REQ cycles before ACK; waits >= TIMEOUT means never ACK.
  // Strobes stay high well past completion (unless dropped early) to prove no second request.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int waits, input logic [15:0] rdata,
                        input logic drop_early);
    int n_stall;
    int n_req;
    int n_err;
    bit to;
    n_stall = 0;
    n_req   = 0;
    n_err   = 0;
    to      = (waits >= TIMEOUT);
    if (rd && !wr) exp_rdata = to ? 16'hFFFF : rdata;

    @(negedge MAIN_CLK);
    MEM_RD = rd;
    MEM_WR = wr;
    ADDR_BUS = addr;
    WRITE_DATA_BUS = wdata;
    EXT_ACK = 1'b0;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      #1;
      if (CPU_STALL) n_stall++;
      if (BUS_ERR) n_err++;
      if (EXT_REQ) begin
        chk("ext_addr_stable", 32'(EXT_ADDR), 32'(addr));
        chk("ext_we_stable", 32'(EXT_WE), 32'(wr));
        chk("ext_wdata_stable", 32'(EXT_WDATA), 32'(wdata));
        EXT_ACK   = (!to && n_req == waits);
        EXT_RDATA = EXT_ACK ? rdata : 16'($urandom);
        n_req++;
      end else begin
        // ACK outside REQ must be ignored, including late ACKs after a timeout.
        EXT_ACK   = 1'($urandom);
        EXT_RDATA = 16'($urandom);
      end
      if (drop_early && n_req > 0) begin
        MEM_RD = 1'b0;
        MEM_WR = 1'b0;
      end
      @(negedge MAIN_CLK);
    end
    #1;
    chk("stall_cycles", 32'(n_stall), to ? 32'(TIMEOUT + 2) : 32'(waits + 2));
    chk("req_cycles", 32'(n_req), to ? 32'(TIMEOUT) : 32'(waits + 1));
    chk("bus_err_pulses", 32'(n_err), to ? 32'd1 : 32'd0);
    chk("read_data", 32'(READ_DATA_BUS), 32'(exp_rdata));
    chk("ext_req_idle", 32'(EXT_REQ), 32'd0);
    chk("stall_after", 32'(CPU_STALL), 32'd0);
    chk("ext_addr_held", 32'(EXT_ADDR), 32'(addr));
    chk("ext_we_held", 32'(EXT_WE), 32'(wr));
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    EXT_ACK = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    exp_rdata      = 16'h0000;
    MAIN_RST       = 1'b1;
    ADDR_BUS       = '0;
    WRITE_DATA_BUS = '0;
    MEM_RD         = 1'b0;
    MEM_WR         = 1'b0;
    EXT_RDATA      = '0;
    EXT_ACK        = 1'b0;

    #2;
    chk("rst_read_data", 32'(READ_DATA_BUS), 32'd0);
    chk("rst_stall", 32'(CPU_STALL), 32'd0);
    chk("rst_bus_err", 32'(BUS_ERR), 32'd0);
    chk("rst_ext_req", 32'(EXT_REQ), 32'd0);
    chk("rst_ext_addr", 32'(EXT_ADDR), 32'd0);
    chk("rst_ext_wdata", 32'(EXT_WDATA), 32'd0);
    chk("rst_ext_we", 32'(EXT_WE), 32'd0);
    @(negedge MAIN_CLK);
    MAIN_RST = 1'b0;

    do_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 0, 16'hBEEF, 1'b0);
    do_txn(1'b0, 1'b1, 16'h0100, 16'h1234, 3, 16'h5555, 1'b0);
    do_txn(1'b1, 1'b0, 16'h0200, 16'h0000, 99, 16'h7777, 1'b0);
    do_txn(1'b1, 1'b1, 16'h0300, 16'hCAFE, 1, 16'h9999, 1'b0);
    do_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 16'h1111, 1'b0);
    do_txn(1'b1, 1'b0, 16'h0012, 16'h0000, 2, 16'h2222, 1'b0);

    // Reset during the second REQ wait cycle, strobe still held.
    @(negedge MAIN_CLK);
    MEM_RD   = 1'b1;
    ADDR_BUS = 16'h0077;
    EXT_ACK  = 1'b0;
    @(negedge MAIN_CLK);
    @(negedge MAIN_CLK);
    #1;
    chk("pre_rst_ext_req", 32'(EXT_REQ), 32'd1);
    MAIN_RST = 1'b1;
    #1;
    chk("arst_ext_req", 32'(EXT_REQ), 32'd0);
    chk("arst_stall", 32'(CPU_STALL), 32'd0);
    chk("arst_bus_err", 32'(BUS_ERR), 32'd0);
    chk("arst_read_data", 32'(READ_DATA_BUS), 32'd0);
    exp_rdata = 16'h0000;
    MEM_RD = 1'b0;
    @(negedge MAIN_CLK);
    MAIN_RST = 1'b0;
    do_txn(1'b1, 1'b0, 16'h0002, 16'h0000, 1, 16'hA5A5, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      do_txn(op[0], op[1], 16'($urandom), 16'($urandom), $urandom_range(0, TIMEOUT + 3),
             16'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
